// File: rtl/i2c_master_pkg.sv
// ---------------------------------------------------------------------------
// i2c_master_pkg
// Shared types and helpers for the I2C master datapath.
//   bit_op_ctrl_e / bit_op_t : one bus-level operation for bit_operation.
//   OPS_PER_BYTE, MAX_OPS    : op-count constants for one register transaction.
//   seq_field_e              : which byte/field of a transaction is being expanded.
//   byte_ops()               : the op at index 0..8 of one byte (8 bits + ACK slot).
//   op_count()               : total ops for a transaction shape.
// ---------------------------------------------------------------------------
package i2c_master_pkg;

    typedef enum logic [1:0] {
        SEND        = 2'd0,
        RECEIVE     = 2'd1,
        RECEIVE_ACK = 2'd2,
        RESTART     = 2'd3
    } bit_op_ctrl_e;

    typedef struct packed {
        bit_op_ctrl_e ctrl;
        logic         data;
    } bit_op_t;

    localparam int OPS_PER_BYTE = 9;
    localparam int MAX_OPS      = 55;

    typedef enum logic [3:0] {
        F_DEVW    = 4'd0,
        F_REG_HI  = 4'd1,
        F_REG_LO  = 4'd2,
        F_DATA_HI = 4'd3,
        F_DATA_LO = 4'd4,
        F_RESTART = 4'd5,
        F_DEVR    = 4'd6,
        F_RD_HI   = 4'd7,
        F_RD_LO   = 4'd8
    } seq_field_e;

    // Indices 0..7 carry the byte MSB first; index 8 is the acknowledge slot.
    // For a byte we transmit, the slave acknowledges (RECEIVE_ACK). For a byte
    // we receive, we drive the acknowledge ourselves: 0 = ACK, 1 = NACK on last.
    function automatic bit_op_t byte_ops(input logic [7:0] data_byte,
                                         input logic       is_read,
                                         input logic       last,
                                         input logic [3:0] idx);
        bit_op_t    op;
        logic [2:0] bit_sel;
        op.ctrl = SEND;
        op.data = 1'b0;
        bit_sel = 3'd7 - idx[2:0];
        if (idx < 4'd8) begin
            if (is_read) op.ctrl = RECEIVE;
            else         op.data = data_byte[bit_sel];
        end else begin
            if (is_read) op.data = last;
            else         op.ctrl = RECEIVE_ACK;
        end
        return op;
    endfunction

    function automatic logic [5:0] op_count(input logic rnw,
                                            input logic addr_2b,
                                            input logic data_2b);
        int na;
        int nd;
        int n;
        na = addr_2b ? 2 : 1;
        nd = data_2b ? 2 : 1;
        if (rnw) n = OPS_PER_BYTE * (1 + na) + 1 + OPS_PER_BYTE * (1 + nd);
        else     n = OPS_PER_BYTE * (1 + na + nd);
        return 6'(n);
    endfunction

endpackage

// File: rtl/i2c_transaction_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_transaction_sequencer
// Register-level front end of the I2C master. Expands one register read or
// write request into the bit_op_t stream for bit_operation, starts it, waits
// for completion, assembles read data from the rx queue and returns a
// one-cycle response.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_*                   request handshake and fields (captured in IDLE)
//   bit_op_o/push_bit_op_o  op queue write port of bit_operation
//   start_o                 start pulse to bit_operation
//   op_busy_i/op_done_i/op_error_i  bit_operation status
//   rx_bit_i/rx_bit_queue_empty_i/pull_rx_bit_o  rx queue read port
//   resp_valid_o/resp_error_o/resp_rd_data_o     completion response
// ---------------------------------------------------------------------------
module i2c_transaction_sequencer
    import i2c_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int OP_QUEUE_DEPTH = 64
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_rnw_i,
    input  logic [6:0]    req_dev_addr_i,
    input  logic          req_addr_2b_i,
    input  logic          req_data_2b_i,
    input  logic [15:0]   req_reg_addr_i,
    input  logic [15:0]   req_wr_data_i,
    output bit_op_t       bit_op_o,
    output logic          push_bit_op_o,
    output logic          start_o,
    input  logic          op_busy_i,
    input  logic          op_done_i,
    input  logic          op_error_i,
    input  logic          rx_bit_i,
    input  logic          rx_bit_queue_empty_i,
    output logic          pull_rx_bit_o,
    output logic          resp_valid_o,
    output logic          resp_error_o,
    output logic [15:0]   resp_rd_data_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // A full 2-byte-address, 2-byte-data read must fit in the op queue,
    // because every op is pushed before start.
    generate
        if (OP_QUEUE_DEPTH < MAX_OPS) begin : g_depth_check
            $error("OP_QUEUE_DEPTH too small for a full register transaction");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PUSH      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_PULL      = 3'd4,
        S_DRAIN     = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    state_e      r_state;
    state_e      w_next_state;

    // Captured request
    logic        r_rnw;
    logic [6:0]  r_dev;
    logic        r_a2;
    logic        r_d2;
    logic [15:0] r_reg;
    logic [15:0] r_wr;

    // Op generation
    seq_field_e  r_field;
    seq_field_e  w_next_field;
    logic [3:0]  r_bit_idx;
    logic [5:0]  r_op_cnt;
    logic [5:0]  r_op_total;
    bit_op_t     w_cur_op;
    logic        w_field_end;
    logic        w_last_op;

    // Completion / read-back
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_hit;
    logic [4:0]      r_bits_rem;
    logic [15:0]     r_shift;
    logic            r_err;
    logic            w_set_err;
    logic [15:0]     r_resp_data;
    logic            w_accept;
    logic            w_pull;
    logic            w_push;

    assign w_accept    = (r_state == S_IDLE) && req_valid_i;
    assign w_field_end = (r_field == F_RESTART) || (r_bit_idx == 4'd8);
    assign w_last_op   = (r_op_cnt == (r_op_total - 6'd1));
    assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------
    // Op selection: field + bit index -> bit_op_t
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_op = '0;
        case (r_field)
            F_DEVW:    w_cur_op = byte_ops({r_dev, 1'b0}, 1'b0, 1'b0, r_bit_idx);
            F_REG_HI:  w_cur_op = byte_ops(r_reg[15:8],   1'b0, 1'b0, r_bit_idx);
            F_REG_LO:  w_cur_op = byte_ops(r_reg[7:0],    1'b0, 1'b0, r_bit_idx);
            F_DATA_HI: w_cur_op = byte_ops(r_wr[15:8],    1'b0, 1'b0, r_bit_idx);
            F_DATA_LO: w_cur_op = byte_ops(r_wr[7:0],     1'b0, 1'b0, r_bit_idx);
            F_RESTART: begin
                w_cur_op.ctrl = RESTART;
                w_cur_op.data = 1'b0;
            end
            F_DEVR:    w_cur_op = byte_ops({r_dev, 1'b1}, 1'b0, 1'b0, r_bit_idx);
            F_RD_HI:   w_cur_op = byte_ops(8'h00,         1'b1, 1'b0, r_bit_idx);
            F_RD_LO:   w_cur_op = byte_ops(8'h00,         1'b1, 1'b1, r_bit_idx);
            default:   w_cur_op = '0;
        endcase
    end

    // Field order on the wire. The final field has no successor; the op
    // counter ends the push phase there.
    always_comb begin
        w_next_field = r_field;
        case (r_field)
            F_DEVW:    w_next_field = r_a2 ? F_REG_HI : F_REG_LO;
            F_REG_HI:  w_next_field = F_REG_LO;
            F_REG_LO:  w_next_field = r_rnw ? F_RESTART : (r_d2 ? F_DATA_HI : F_DATA_LO);
            F_DATA_HI: w_next_field = F_DATA_LO;
            F_RESTART: w_next_field = F_DEVR;
            F_DEVR:    w_next_field = r_d2 ? F_RD_HI : F_RD_LO;
            F_RD_HI:   w_next_field = F_RD_LO;
            default:   w_next_field = r_field;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        req_ready_o  = 1'b0;
        w_push       = 1'b0;
        bit_op_o     = '0;
        start_o      = 1'b0;
        w_pull       = 1'b0;
        resp_valid_o = 1'b0;
        resp_error_o = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_next_state = S_PUSH;
            end
            S_PUSH: begin
                w_push   = 1'b1;
                bit_op_o = w_cur_op;
                if (w_last_op) w_next_state = S_START;
            end
            S_START: begin
                // Hold off while bit_operation is still busy from earlier work.
                if (!op_busy_i) begin
                    start_o      = 1'b1;
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (op_done_i) begin
                    if (op_error_i) begin
                        w_set_err    = 1'b1;
                        w_next_state = S_DRAIN;
                    end else if (r_rnw) begin
                        w_next_state = S_PULL;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end else if (w_to_hit) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_DRAIN;
                end
            end
            S_PULL: begin
                if (r_bits_rem == 5'd0) begin
                    w_next_state = S_DRAIN;
                end else if (!rx_bit_queue_empty_i) begin
                    w_pull = 1'b1;
                    if (r_bits_rem == 5'd1) w_next_state = S_DRAIN;
                end else begin
                    // Fewer bits came back than the transaction received.
                    w_set_err    = 1'b1;
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!rx_bit_queue_empty_i) w_pull = 1'b1;
                else                       w_next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_error_o = r_err;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign push_bit_op_o  = w_push;
    assign pull_rx_bit_o  = w_pull;
    assign resp_rd_data_o = r_resp_data;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_field     <= F_DEVW;
            r_bit_idx   <= 4'd0;
            r_op_cnt    <= 6'd0;
            r_op_total  <= 6'd0;
            r_to_cnt    <= '0;
            r_bits_rem  <= 5'd0;
            r_err       <= 1'b0;
            r_resp_data <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_field    <= F_DEVW;
                        r_bit_idx  <= 4'd0;
                        r_op_cnt   <= 6'd0;
                        r_op_total <= op_count(req_rnw_i, req_addr_2b_i, req_data_2b_i);
                        r_bits_rem <= req_data_2b_i ? 5'd16 : 5'd8;
                        r_err      <= 1'b0;
                    end
                end
                S_PUSH: begin
                    r_op_cnt <= r_op_cnt + 6'd1;
                    if (w_field_end) begin
                        r_field   <= w_next_field;
                        r_bit_idx <= 4'd0;
                    end else begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
                S_START:     r_to_cnt <= '0;
                S_WAIT_DONE: r_to_cnt <= r_to_cnt + 1'b1;
                S_PULL: begin
                    if (w_pull) r_bits_rem <= r_bits_rem - 5'd1;
                end
                default: ;
            endcase
            if (w_set_err) r_err <= 1'b1;
            // Read data is published only for an error-free read; it then
            // holds until the next response.
            if (r_state == S_DRAIN && w_next_state == S_RESP)
                r_resp_data <= (r_err || !r_rnw) ? 16'h0000 : r_shift;
        end
    end

    // ------------------------------------------------------------------
    // Request fields and read shift register (no reset needed: always
    // loaded on accept before use)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_rnw   <= req_rnw_i;
            r_dev   <= req_dev_addr_i;
            r_a2    <= req_addr_2b_i;
            r_d2    <= req_data_2b_i;
            r_reg   <= req_addr_2b_i ? req_reg_addr_i : {8'h00, req_reg_addr_i[7:0]};
            r_wr    <= req_data_2b_i ? req_wr_data_i  : {8'h00, req_wr_data_i[7:0]};
            r_shift <= 16'h0000;
        end else if (r_state == S_PULL && w_pull) begin
            // Bits arrive MSB first; shifting in at the LSB leaves a single
            // byte zero-extended.
            r_shift <= {r_shift[14:0], rx_bit_i};
        end
    end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
`timescale 1ns/1ps
module tb_i2c_transaction_sequencer;
    import i2c_master_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_rnw, req_a2, req_d2;
    logic [6:0]  req_dev;
    logic [15:0] req_reg, req_wr;
    bit_op_t     bit_op;
    logic        push_op, start, op_busy, op_done, op_error;
    logic        rx_bit, rx_empty, pull_rx;
    logic        resp_valid, resp_error;
    logic [15:0] resp_data;

    i2c_transaction_sequencer #(.TIMEOUT_CYCLES(100), .OP_QUEUE_DEPTH(64)) u_dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_rnw_i            (req_rnw),
        .req_dev_addr_i       (req_dev),
        .req_addr_2b_i        (req_a2),
        .req_data_2b_i        (req_d2),
        .req_reg_addr_i       (req_reg),
        .req_wr_data_i        (req_wr),
        .bit_op_o             (bit_op),
        .push_bit_op_o        (push_op),
        .start_o              (start),
        .op_busy_i            (op_busy),
        .op_done_i            (op_done),
        .op_error_i           (op_error),
        .rx_bit_i             (rx_bit),
        .rx_bit_queue_empty_i (rx_empty),
        .pull_rx_bit_o        (pull_rx),
        .resp_valid_o         (resp_valid),
        .resp_error_o         (resp_error),
        .resp_rd_data_o       (resp_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] mk(input bit_op_ctrl_e c, input logic d);
        return {c, d};
    endfunction

    // Scoreboard queues
    logic [2:0]  exp_ops[$];
    logic [16:0] exp_resp[$];

    // bit_operation model state
    logic        rxq[$];
    logic [15:0] m_word;
    int          m_nbits, m_stale, m_cnt;
    logic        m_err, m_noreply;
    bit          start_pend, pop_pend;

    int          push_cnt, start_cnt, pull_cnt, resp_cnt, cyc, start_cyc, resp_cyc;
    logic [2:0]  got_ops[64];

    // Monitor (mid-cycle) + bit_operation / rx queue model (just after edge)
    initial begin
        op_busy = 0; op_done = 0; op_error = 0; rx_bit = 0; rx_empty = 1;
        m_cnt = 0; start_pend = 0; pop_pend = 0;
        push_cnt = 0; start_cnt = 0; pull_cnt = 0; resp_cnt = 0; cyc = 0;
        start_cyc = 0; resp_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (push_op) begin
                chk("push_pull_overlap", 32'(pull_rx), 32'd0);
                chk("op_expected", 32'(exp_ops.size() != 0), 32'd1);
                if (exp_ops.size() != 0)
                    chk($sformatf("op%0d", push_cnt), 32'(bit_op), 32'(exp_ops.pop_front()));
                if (push_cnt < 64) got_ops[push_cnt] = bit_op;
                push_cnt++;
            end
            if (start) begin
                chk("start_while_busy", 32'(op_busy), 32'd0);
                start_cnt++;
                start_cyc  = cyc;
                start_pend = 1;
            end
            if (pull_rx) begin
                pop_pend = 1;
                pull_cnt++;
            end
            if (resp_valid) begin
                resp_cnt++;
                resp_cyc = cyc;
                chk("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
                if (exp_resp.size() != 0) begin
                    logic [16:0] e;
                    e = exp_resp.pop_front();
                    chk("resp_error", 32'(resp_error), 32'(e[16]));
                    chk("resp_data", 32'(resp_data), 32'(e[15:0]));
                end
                chk("rxq_empty_at_resp", 32'(rxq.size()), 32'd0);
            end
            @(posedge clk);
            #1;
            if (pop_pend) begin
                if (rxq.size() > 0) void'(rxq.pop_front());
                pop_pend = 0;
            end
            if (op_done) begin
                op_done = 0; op_error = 0; op_busy = 0;
            end
            if (start_pend) begin
                start_pend = 0;
                if (!m_noreply) begin
                    op_busy = 1;
                    m_cnt   = 6;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int i = 0; i < m_nbits; i++) rxq.push_back(m_word[m_nbits-1-i]);
                    for (int i = 0; i < m_stale; i++) rxq.push_back(1'b1);
                    op_done  = 1;
                    op_error = m_err;
                end
            end
            rx_empty = (rxq.size() == 0);
            rx_bit   = (rxq.size() != 0) ? rxq[0] : 1'b0;
        end
    end

    task automatic exp_byte(input logic rd, input logic [7:0] b, input logic last);
        for (int i = 7; i >= 0; i--)
            exp_ops.push_back(rd ? mk(RECEIVE, 1'b0) : mk(SEND, b[i]));
        exp_ops.push_back(rd ? mk(SEND, last) : mk(RECEIVE_ACK, 1'b0));
    endtask

    task automatic build_ops(input logic rnw, input logic [6:0] dev, input logic a2,
                             input logic d2, input logic [15:0] rg, input logic [15:0] wr);
        exp_byte(1'b0, {dev, 1'b0}, 1'b0);
        if (a2) exp_byte(1'b0, rg[15:8], 1'b0);
        exp_byte(1'b0, rg[7:0], 1'b0);
        if (rnw) begin
            exp_ops.push_back(mk(RESTART, 1'b0));
            exp_byte(1'b0, {dev, 1'b1}, 1'b0);
            if (d2) exp_byte(1'b1, 8'h00, 1'b0);
            exp_byte(1'b1, 8'h00, 1'b1);
        end else begin
            if (d2) exp_byte(1'b0, wr[15:8], 1'b0);
            exp_byte(1'b0, wr[7:0], 1'b0);
        end
    endtask

    task automatic issue(input logic rnw, input logic [6:0] dev, input logic a2,
                         input logic d2, input logic [15:0] rg, input logic [15:0] wr);
        build_ops(rnw, dev, a2, d2, rg, wr);
        push_cnt = 0; start_cnt = 0; pull_cnt = 0;
        @(posedge clk); #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_rnw = rnw; req_dev = dev; req_a2 = a2; req_d2 = d2;
        req_reg = rg; req_wr = wr;
        @(posedge clk); #1;
        // Garbage on the request bus while busy must be ignored.
        req_valid = 0; req_rnw = ~rnw; req_dev = 7'($urandom);
        req_a2 = ~a2; req_d2 = ~d2; req_reg = 16'($urandom); req_wr = 16'($urandom);
    endtask

    task automatic run_req(input string nm, input logic rnw, input logic [6:0] dev,
                           input logic a2, input logic d2, input logic [15:0] rg,
                           input logic [15:0] wr, input logic [15:0] rword, input int nbits,
                           input int stale, input logic err, input logic noreply,
                           input int exp_n, input logic exp_err, input logic [15:0] exp_data);
        int r0;
        int k;
        m_word = rword; m_nbits = nbits; m_stale = stale; m_err = err; m_noreply = noreply;
        exp_resp.push_back({exp_err, exp_data});
        r0 = resp_cnt;
        issue(rnw, dev, a2, d2, rg, wr);
        k = 0;
        while (resp_cnt == r0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_resp_seen"}, 32'(resp_cnt - r0), 32'd1);
        chk({nm, "_push_cnt"}, 32'(push_cnt), 32'(exp_n));
        chk({nm, "_start_cnt"}, 32'(start_cnt), 32'd1);
        chk({nm, "_ops_left"}, 32'(exp_ops.size()), 32'd0);
        chk({nm, "_ready_after"}, 32'(req_ready), 32'd1);
        exp_ops.delete();
    endtask

    initial begin
        int r0;
        int k;
        rst_n = 0; req_valid = 0; req_rnw = 0; req_dev = 0; req_a2 = 0; req_d2 = 0;
        req_reg = 0; req_wr = 0;
        m_word = 0; m_nbits = 0; m_stale = 0; m_err = 0; m_noreply = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_push", 32'(push_op), 32'd0);
        chk("rst_bit_op", 32'(bit_op), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_pull", 32'(pull_rx), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        rst_n = 1;
        repeat (2) @(posedge clk);

        // ADS read first so the later write proves data is cleared to 0.
        run_req("ads_rd", 1'b1, 7'h48, 1'b0, 1'b0, 16'h0084, 16'h0000,
                16'h00A5, 8, 0, 1'b0, 1'b0, 37, 1'b0, 16'h00A5);
        chk("ads_op18_restart", 32'(got_ops[18]), 32'(mk(RESTART, 1'b0)));
        chk("ads_last_nack", 32'(got_ops[36]), 32'(mk(SEND, 1'b1)));
        chk("ads_pulls", 32'(pull_cnt), 32'd8);

        run_req("sgtl_wr", 1'b0, 7'h0A, 1'b1, 1'b1, 16'h0002, 16'h0063,
                16'h0000, 0, 0, 1'b0, 1'b0, 45, 1'b0, 16'h0000);
        chk("wr_op7_bit", 32'(got_ops[6]), 32'(mk(SEND, 1'b0)));
        chk("wr_op4_bit", 32'(got_ops[3]), 32'(mk(SEND, 1'b1)));
        chk("wr_op9_ack", 32'(got_ops[8]), 32'(mk(RECEIVE_ACK, 1'b0)));

        run_req("sgtl_rd", 1'b1, 7'h0A, 1'b1, 1'b1, 16'h0002, 16'h0000,
                16'hAAAA, 16, 0, 1'b0, 1'b0, 55, 1'b0, 16'hAAAA);
        chk("sgtl_ack_byte1", 32'(got_ops[45]), 32'(mk(SEND, 1'b0)));
        chk("sgtl_nack_last", 32'(got_ops[54]), 32'(mk(SEND, 1'b1)));
        chk("sgtl_rxq_empty", 32'(rxq.size()), 32'd0);

        run_req("nack_err", 1'b1, 7'h48, 1'b0, 1'b0, 16'h0084, 16'h0000,
                16'h0000, 0, 3, 1'b1, 1'b0, 37, 1'b1, 16'h0000);
        chk("nack_drain_pulls", 32'(pull_cnt), 32'd3);

        r0 = resp_cnt;
        run_req("timeout", 1'b0, 7'h20, 1'b0, 1'b0, 16'h0011, 16'h0022,
                16'h0000, 0, 0, 1'b0, 1'b1, 27, 1'b1, 16'h0000);
        chk("timeout_latency", 32'(resp_cyc - start_cyc), 32'd102);
        repeat (150) @(posedge clk);
        #1;
        chk("timeout_single_resp", 32'(resp_cnt - r0), 32'd1);
        chk("timeout_ready", 32'(req_ready), 32'd1);
        m_noreply = 0;

        // Reset in the middle of the op push phase
        issue(1'b0, 7'h0A, 1'b1, 1'b1, 16'h0030, 16'hBEEF);
        k = 0;
        while (push_cnt < 20 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_push_reached", 32'(push_cnt), 32'd20);
        rst_n = 0;
        #1;
        chk("midrst_push", 32'(push_op), 32'd0);
        chk("midrst_bit_op", 32'(bit_op), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_ops_remaining", 32'(exp_ops.size()), 32'd25);
        exp_ops.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clk);

        run_req("post_rst_wr", 1'b0, 7'h0A, 1'b1, 1'b1, 16'h0030, 16'hBEEF,
                16'h0000, 0, 0, 1'b0, 1'b0, 45, 1'b0, 16'h0000);
        chk("post_rst_first_op", 32'(got_ops[0]), 32'(mk(SEND, 1'b0)));

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_transaction_sequencer.md
Name: i2c_transaction_sequencer

Overview:
- Register-level front end of the I2C master. Sits directly upstream of bit_operation.
- Accepts one register read/write request from the control logic and expands it into the ordered bit_op_t stream, pushed one op per cycle into bit_operation's queue.
- Pulses bit_operation start_i, waits for done_o, then pulls received data bits from the rx queue and assembles read data.
- Returns a one-cycle response with data and an error flag.
- Covers the SGTL5000 (16-bit address, 16-bit data) and ADS7830 (8-bit command, 8-bit data) transaction formats.

Parameters:
- TIMEOUT_CYCLES, default 2000000: clk_i cycles allowed in WAIT_DONE before the transaction is aborted with an error.
- OP_QUEUE_DEPTH, default 64: depth of the bit_operation op queue; used only for an elaboration-time check that it is at least 55.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous reset, active-low
- req_valid_i  in  1  request strobe, accepted when req_ready_o=1
- req_ready_o  out  1  high only in IDLE
- req_rnw_i  in  1  1=read, 0=write
- req_dev_addr_i  in  7  7-bit I2C device address
- req_addr_2b_i  in  1  0=1 address byte (reg_addr[7:0]), 1=2 bytes
- req_data_2b_i  in  1  0=1 data byte ([7:0]), 1=2 bytes
- req_reg_addr_i  in  16  register address / command byte
- req_wr_data_i  in  16  write data
- bit_op_o  out  3  bit_op_t to bit_operation
- push_bit_op_o  out  1  push strobe
- start_o  out  1  start pulse
- op_busy_i  in  1  bit_operation busy_o
- op_done_i  in  1  bit_operation done_o
- op_error_i  in  1  bit_operation error_o (NACK seen on RECEIVE_ACK)
- rx_bit_i  in  1  head of rx queue (show-ahead)
- rx_bit_queue_empty_i  in  1  rx queue empty
- pull_rx_bit_o  out  1  pop rx queue
- resp_valid_o  out  1  one-cycle completion pulse
- resp_error_o  out  1  valid with resp_valid_o
- resp_rd_data_o  out  16  read data, zero-extended when 1 data byte

Behaviour:
- Reset values: req_ready_o=1 (state IDLE); all other outputs 0, including bit_op_o, resp_rd_data_o and every strobe.
- Reset mid-transaction returns to IDLE immediately. No ops are pushed after reset; bit_operation has its own reset.
- Request capture: on req_valid_i & req_ready_o, all req_* fields are registered and the FSM goes to PUSH. Request fields are ignored while busy.
- Op stream, in bus order (first pushed = first on wire), each byte MSB first:
  - Write: A = {dev,0}, then SEND×8 + RECEIVE_ACK; each address byte SEND×8 + RECEIVE_ACK; each data byte SEND×8 + RECEIVE_ACK.
  - Read: A; address bytes as for write; one RESTART; {dev,1} SEND×8 + RECEIVE_ACK; each data byte RECEIVE×8 followed by SEND data=0 (ACK), except the last byte, which gets SEND data=1 (NACK).
  - Data field of RECEIVE, RECEIVE_ACK and RESTART ops is 0.
- Op count: write = 9·(1+Na+Nd); read = 9·(1+Na)+1+9·(1+Nd). Maximum 55 (read, Na=2, Nd=2); 2/2 write = 45; ADS 1/1 read = 37.
- PUSH: push_bit_op_o=1 for exactly N consecutive cycles, one op per cycle, no gaps. An op counter plus a field index selects the op.
- START: start_o=1 for one cycle, the cycle after the last push.
- WAIT_DONE:
  - On op_done_i: go to DRAIN if op_error_i=1 or write; go to PULL if read and no error.
  - Timeout counter reaching TIMEOUT_CYCLES: resp_error_o=1, then DRAIN.
- PULL: while !rx_bit_queue_empty_i and bits remaining > 0:
  - pull_rx_bit_o=1; shift rx_bit_i into data LSB (MSB-first assembly); 8·Nd bits total.
  - If the queue goes empty before all bits are collected, flag error and go to DRAIN.
- DRAIN: pull while !rx_bit_queue_empty_i, discarding bits, so no stale bits remain for the next transaction. Then go to RESP.
- RESP: resp_valid_o=1 for one cycle.
  - resp_rd_data_o holds its value until the next resp_valid_o.
  - resp_rd_data_o is 0 for writes and on any error.
  - Next cycle returns to IDLE.
- Latency, write, no error: accept + N push + 1 start + bus time + 1 drain check + 1 resp.
- Never asserts push_bit_op_o and pull_rx_bit_o in the same cycle. Never asserts start_o while op_busy_i=1.

Decomposition:
- bit_op_t and its control enum (SEND, RECEIVE, RECEIVE_ACK, RESTART) come from i2c_master_pkg.
- Add to i2c_master_pkg:
  - op-count constants (OPS_PER_BYTE=9, MAX_OPS=55);
  - a function byte_ops(byte, is_read, last) returning the bit_op_t for index 0..8.
- No sub-module; a single FSM plus op counter, bit counter and timeout counter.

Test Plan:
- Write dev=7'h0A, addr=16'h0002, data=16'h0063, 2/2 bytes → exactly 45 pushes: first 7 SEND carry 0,0,0,1,0,1,0, op8 SEND 0, op9 RECEIVE_ACK; one start pulse; resp_valid with error=0, data=0.
- Read dev=7'h48, cmd=8'h84, 1/1 bytes with a bit_operation model returning 8'hA5 → 37 pushes, RESTART at op index 18, last op SEND 1; resp_rd_data=16'h00A5.
- SGTL read 2/2, model returns 16'hAAAA → 55 pushes, ACK SEND 0 after the first data byte; resp_rd_data=16'hAAAA; rx queue empty afterwards.
- Model asserts op_error_i with 3 stale rx bits queued → DRAIN pulls 3; resp_error=1, data=0.
- op_done_i never asserted, TIMEOUT_CYCLES=100 → resp_error=1 exactly once after the timeout; req_ready_o back to 1.
- rst_n_i low mid-PUSH at op 20 → outputs reset immediately; next request produces a clean full op stream.
